exc_arbiter: RTL and testbench

EXC_ARBITER -- requirements
Module: exc_arbiter

---
 rtl/exc_arbiter_pkg.sv | 34 +++
 rtl/exc_prio_enc.sv | 55 +++++
 rtl/exc_arbiter.sv | 146 ++++++++++++++
 tb/tb_exc_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_arbiter_pkg.sv
// exc_arbiter_pkg
//   Shared definitions for the exception arbiter: CP0 exception codes,
//   the exception code bus width, the arbiter state encoding and the
//   bad-address source select used between the priority encoder and the top.
package exc_arbiter_pkg;

   localparam int EXC_CODE_BUS = 5;
   localparam int FLUSH_CNT_W  = 3;

   typedef logic [EXC_CODE_BUS-1:0] exc_code_t;

   localparam exc_code_t EXC_INT  = 5'h00;
   localparam exc_code_t EXC_ADEL = 5'h04;
   localparam exc_code_t EXC_ADES = 5'h05;
   localparam exc_code_t EXC_SYS  = 5'h08;
   localparam exc_code_t EXC_BP   = 5'h09;
   localparam exc_code_t EXC_RI   = 5'h0a;
   localparam exc_code_t EXC_OV   = 5'h0c;
   localparam exc_code_t EXC_NONE = 5'h10;
   localparam exc_code_t EXC_ERET = 5'h11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } exc_state_e;

   // Where badvaddr comes from for the selected exception.
   typedef enum logic [1:0] {
      BAD_NONE = 2'd0,
      BAD_PC   = 2'd1,
      BAD_DATA = 2'd2
   } bad_sel_e;

endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc
//   Purely combinational fixed-priority exception encoder.
//   Ports:
//     valid        in   MEM stage holds a valid instruction; gates every candidate
//     int_pending  in   qualified interrupt request
//     if_adel .. id_eret  in  individual exception candidates
//     code         out  selected exception code, EXC_NONE if nothing selected
//     bad_sel      out  source of the bad virtual address for the selected code
module exc_prio_enc
   import exc_arbiter_pkg::*;
(
   input  logic      valid,
   input  logic      int_pending,
   input  logic      if_adel,
   input  logic      id_ri,
   input  logic      id_sys,
   input  logic      id_bp,
   input  logic      ex_ov,
   input  logic      mem_adel,
   input  logic      mem_ades,
   input  logic      id_eret,
   output exc_code_t code,
   output bad_sel_e  bad_sel
);

   always_comb begin
      code    = EXC_NONE;
      bad_sel = BAD_NONE;
      if (valid) begin
         if (int_pending) begin
            code = EXC_INT;
         end else if (if_adel) begin
            code    = EXC_ADEL;
            bad_sel = BAD_PC;
         end else if (id_ri) begin
            code = EXC_RI;
         end else if (id_sys) begin
            code = EXC_SYS;
         end else if (id_bp) begin
            code = EXC_BP;
         end else if (ex_ov) begin
            code = EXC_OV;
         end else if (mem_adel) begin
            code    = EXC_ADEL;
            bad_sel = BAD_DATA;
         end else if (mem_ades) begin
            code    = EXC_ADES;
            bad_sel = BAD_DATA;
         end else if (id_eret) begin
            code = EXC_ERET;
         end
      end
   end

endmodule

// File: rtl/exc_arbiter.sv
// exc_arbiter
//   Selects at most one exception for the MEM-stage instruction, presents it
//   to CP0 in the commit cycle and then holds the pipeline flushed for
//   FLUSH_CYCLES further cycles.
//   Ports:
//     cpu_clk_50M, cpu_rst        clock, synchronous active-high reset
//     mem_valid, mem_stall        MEM stage qualifiers
//     mem_pc, mem_in_delay        MEM instruction PC and delay-slot flag
//     if_adel, id_*, ex_ov, mem_adel, mem_ades   exception candidates
//     mem_badvaddr                faulting data address
//     status_i, cause_i           CP0 Status / Cause for interrupt qualification
//     exccode_o, pc_o, badvaddr_o, in_delay_o    exception info to CP0
//     flush_o, busy_o             pipeline flush, FLUSH-state indicator
//     exc_cnt_o                   saturating count of committed exceptions (ERET excluded)
//     dbg_state                   current arbiter state
//   Handshake: an exception commits in a cycle where the arbiter is IDLE,
//   mem_valid=1, mem_stall=0 and a code is selected; no back-pressure exists,
//   the commit is a single-cycle pulse on exccode_o != EXC_NONE.
module exc_arbiter
   import exc_arbiter_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2   // legal range 1..7
)(
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst,
   input  logic        mem_valid,
   input  logic        mem_stall,
   input  logic [31:0] mem_pc,
   input  logic        mem_in_delay,
   input  logic        if_adel,
   input  logic        id_ri,
   input  logic        id_sys,
   input  logic        id_bp,
   input  logic        id_eret,
   input  logic        ex_ov,
   input  logic        mem_adel,
   input  logic        mem_ades,
   input  logic [31:0] mem_badvaddr,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   output exc_code_t   exccode_o,
   output logic [31:0] pc_o,
   output logic [31:0] badvaddr_o,
   output logic        in_delay_o,
   output logic        flush_o,
   output logic        busy_o,
   output logic [15:0] exc_cnt_o,
   output exc_state_e  dbg_state
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   exc_state_e             state, state_next;
   logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_next;
   logic [15:0]            exc_cnt;
   logic                   int_pending;
   logic                   commit;
   exc_code_t              sel_code;
   bad_sel_e               bad_sel;

   // Only IE, EXL and the IM/IP fields take part in interrupt qualification.
   logic unused_bits;
   assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

   assign int_pending = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));

   exc_prio_enc u_prio (
      .valid       (mem_valid),
      .int_pending (int_pending),
      .if_adel     (if_adel),
      .id_ri       (id_ri),
      .id_sys      (id_sys),
      .id_bp       (id_bp),
      .ex_ov       (ex_ov),
      .mem_adel    (mem_adel),
      .mem_ades    (mem_ades),
      .id_eret     (id_eret),
      .code        (sel_code),
      .bad_sel     (bad_sel)
   );

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         state     <= ST_IDLE;
         flush_cnt <= '0;
         exc_cnt   <= '0;
      end else begin
         state     <= state_next;
         flush_cnt <= flush_cnt_next;
         // ERET flushes the pipe but is a return, not an exception.
         if (commit && (sel_code != EXC_ERET) && (exc_cnt != 16'hFFFF)) begin
            exc_cnt <= exc_cnt + 16'd1;
         end
      end
   end

   always_comb begin
      state_next     = state;
      flush_cnt_next = flush_cnt;
      commit         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!cpu_rst && mem_valid && !mem_stall && (sel_code != EXC_NONE)) begin
               commit         = 1'b1;
               state_next     = ST_FLUSH;
               flush_cnt_next = FLUSH_LOAD;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt == '0) begin
               state_next = ST_IDLE;
            end else begin
               flush_cnt_next = flush_cnt - 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      exccode_o  = EXC_NONE;
      pc_o       = '0;
      badvaddr_o = '0;
      in_delay_o = 1'b0;
      flush_o    = 1'b0;
      busy_o     = 1'b0;
      if (!cpu_rst) begin
         pc_o    = mem_pc;
         busy_o  = (state == ST_FLUSH);
         flush_o = commit | (state == ST_FLUSH);
         if (commit) begin
            exccode_o  = sel_code;
            in_delay_o = mem_in_delay;
            case (bad_sel)
               BAD_PC:   badvaddr_o = mem_pc;
               BAD_DATA: badvaddr_o = mem_badvaddr;
               default:  badvaddr_o = '0;
            endcase
         end
      end
   end

   assign exc_cnt_o = exc_cnt;
   assign dbg_state = state;

endmodule

// File: tb/tb_exc_arbiter.sv
// tb_exc_arbiter
//   Directed bench for exc_arbiter with FLUSH_CYCLES = 2. Inputs change 1 ns
//   after the rising edge; outputs are sampled on the falling edge.
module tb_exc_arbiter;
   import exc_arbiter_pkg::*;

   localparam int FC = 2;

   logic        cpu_clk_50M;
   logic        cpu_rst;
   logic        mem_valid, mem_stall, mem_in_delay;
   logic [31:0] mem_pc, mem_badvaddr, status_i, cause_i;
   logic        if_adel, id_ri, id_sys, id_bp, id_eret, ex_ov, mem_adel, mem_ades;
   exc_code_t   exccode_o;
   logic [31:0] pc_o, badvaddr_o;
   logic        in_delay_o, flush_o, busy_o;
   logic [15:0] exc_cnt_o;
   exc_state_e  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   exc_arbiter #(.FLUSH_CYCLES(FC)) dut (
      .cpu_clk_50M  (cpu_clk_50M),
      .cpu_rst      (cpu_rst),
      .mem_valid    (mem_valid),
      .mem_stall    (mem_stall),
      .mem_pc       (mem_pc),
      .mem_in_delay (mem_in_delay),
      .if_adel      (if_adel),
      .id_ri        (id_ri),
      .id_sys       (id_sys),
      .id_bp        (id_bp),
      .id_eret      (id_eret),
      .ex_ov        (ex_ov),
      .mem_adel     (mem_adel),
      .mem_ades     (mem_ades),
      .mem_badvaddr (mem_badvaddr),
      .status_i     (status_i),
      .cause_i      (cause_i),
      .exccode_o    (exccode_o),
      .pc_o         (pc_o),
      .badvaddr_o   (badvaddr_o),
      .in_delay_o   (in_delay_o),
      .flush_o      (flush_o),
      .busy_o       (busy_o),
      .exc_cnt_o    (exc_cnt_o),
      .dbg_state    (dbg_state)
   );

   // clock / reset
   initial cpu_clk_50M = 1'b0;
   always #5 cpu_clk_50M = ~cpu_clk_50M;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge cpu_clk_50M);
      #1;
   endtask

   task automatic sample();
      @(negedge cpu_clk_50M);
   endtask

   task automatic clear_inputs();
      mem_valid    = 1'b0;
      mem_stall    = 1'b0;
      mem_in_delay = 1'b0;
      mem_pc       = 32'h0;
      mem_badvaddr = 32'h0;
      status_i     = 32'h0;
      cause_i      = 32'h0;
      if_adel      = 1'b0;
      id_ri        = 1'b0;
      id_sys       = 1'b0;
      id_bp        = 1'b0;
      id_eret      = 1'b0;
      ex_ov        = 1'b0;
      mem_adel     = 1'b0;
      mem_ades     = 1'b0;
   endtask

   // FC cycles of FLUSH: no code, flush and busy high, inputs left as they are.
   task automatic flush_phase(input string tag, input logic [15:0] exp_cnt);
      for (int i = 0; i < FC; i++) begin
         sample();
         check_eq({tag, "_fl_code"},  32'(exccode_o), 32'(EXC_NONE));
         check_eq({tag, "_fl_flush"}, 32'(flush_o), 32'd1);
         check_eq({tag, "_fl_busy"},  32'(busy_o), 32'd1);
         check_eq({tag, "_fl_cnt"},   32'(exc_cnt_o), 32'(exp_cnt));
         next_cycle();
      end
   endtask

   initial begin
      clear_inputs();
      cpu_rst = 1'b1;
      // Candidates present during reset must be masked.
      mem_valid = 1'b1; ex_ov = 1'b1; if_adel = 1'b1; mem_in_delay = 1'b1;
      mem_pc = 32'hBFC00100;
      next_cycle();
      sample();
      check_eq("rst_code",  32'(exccode_o), 32'(EXC_NONE));
      check_eq("rst_flush", 32'(flush_o), 32'd0);
      check_eq("rst_busy",  32'(busy_o), 32'd0);
      check_eq("rst_pc",    pc_o, 32'h0);
      check_eq("rst_badv",  badvaddr_o, 32'h0);
      check_eq("rst_dly",   32'(in_delay_o), 32'd0);
      check_eq("rst_cnt",   32'(exc_cnt_o), 32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      next_cycle();

      // Overflow commit, ex_ov held through FLUSH to show it is ignored.
      cpu_rst = 1'b0;
      clear_inputs();
      mem_valid = 1'b1; ex_ov = 1'b1; mem_pc = 32'hBFC00100;
      sample();
      check_eq("ov_code",  32'(exccode_o), 32'h0c);
      check_eq("ov_pc",    pc_o, 32'hBFC00100);
      check_eq("ov_flush", 32'(flush_o), 32'd1);
      check_eq("ov_busy",  32'(busy_o), 32'd0);
      check_eq("ov_dly",   32'(in_delay_o), 32'd0);
      next_cycle();
      flush_phase("ov", 16'd1);
      clear_inputs();
      sample();
      check_eq("ov_end_flush", 32'(flush_o), 32'd0);
      check_eq("ov_end_busy",  32'(busy_o), 32'd0);
      check_eq("ov_end_cnt",   32'(exc_cnt_o), 32'd1);
      next_cycle();

      // SYSCALL beats store address error; badvaddr stays 0.
      mem_valid = 1'b1; id_sys = 1'b1; mem_ades = 1'b1;
      mem_badvaddr = 32'h00000003; mem_pc = 32'h00400010; mem_in_delay = 1'b1;
      sample();
      check_eq("sys_code", 32'(exccode_o), 32'h08);
      check_eq("sys_badv", badvaddr_o, 32'h0);
      check_eq("sys_dly",  32'(in_delay_o), 32'd1);
      check_eq("sys_pc",   pc_o, 32'h00400010);
      next_cycle();
      clear_inputs();
      flush_phase("sys", 16'd2);

      // Pending interrupt without a valid instruction is not taken.
      status_i = 32'h0000FF01; cause_i = 32'h00000400; id_eret = 1'b1;
      sample();
      check_eq("int_nv_code",  32'(exccode_o), 32'(EXC_NONE));
      check_eq("int_nv_flush", 32'(flush_o), 32'd0);
      next_cycle();

      // Interrupt beats ERET.
      mem_valid = 1'b1;
      sample();
      check_eq("int_code", 32'(exccode_o), 32'h00);
      next_cycle();
      clear_inputs();
      flush_phase("int", 16'd3);

      // EXL set masks the interrupt: ERET commits, counter unchanged.
      status_i = 32'h0000FF03; cause_i = 32'h00000400; id_eret = 1'b1; mem_valid = 1'b1;
      sample();
      check_eq("eret_code",  32'(exccode_o), 32'h11);
      check_eq("eret_flush", 32'(flush_o), 32'd1);
      next_cycle();
      clear_inputs();
      flush_phase("eret", 16'd3);
      sample();
      check_eq("eret_cnt", 32'(exc_cnt_o), 32'd3);
      next_cycle();

      // Load address error held off by stall for 4 cycles.
      mem_valid = 1'b1; mem_adel = 1'b1; mem_stall = 1'b1; mem_badvaddr = 32'h00001235;
      for (int i = 0; i < 4; i++) begin
         sample();
         check_eq("stall_code",  32'(exccode_o), 32'(EXC_NONE));
         check_eq("stall_flush", 32'(flush_o), 32'd0);
         next_cycle();
      end
      mem_stall = 1'b0;
      sample();
      check_eq("adel_code", 32'(exccode_o), 32'h04);
      check_eq("adel_badv", badvaddr_o, 32'h00001235);
      next_cycle();
      clear_inputs();
      flush_phase("adel", 16'd4);

      // Interrupt withdrawn while stalled: nothing taken.
      mem_valid = 1'b1; mem_stall = 1'b1; status_i = 32'h0000FF01; cause_i = 32'h00000400;
      for (int i = 0; i < 2; i++) begin
         sample();
         check_eq("istall_code", 32'(exccode_o), 32'(EXC_NONE));
         next_cycle();
      end
      cause_i = 32'h0; mem_stall = 1'b0;
      sample();
      check_eq("idrop_code",  32'(exccode_o), 32'(EXC_NONE));
      check_eq("idrop_flush", 32'(flush_o), 32'd0);
      check_eq("idrop_cnt",   32'(exc_cnt_o), 32'd4);
      next_cycle();

      // Fetch address error beats RI; badvaddr comes from the PC.
      clear_inputs();
      mem_valid = 1'b1; if_adel = 1'b1; id_ri = 1'b1;
      mem_pc = 32'h80000003; mem_badvaddr = 32'hDEAD0000;
      sample();
      check_eq("ifadel_code", 32'(exccode_o), 32'h04);
      check_eq("ifadel_badv", badvaddr_o, 32'h80000003);
      next_cycle();
      clear_inputs();
      flush_phase("ifadel", 16'd5);

      // RI held continuously: one commit every 1+FC cycles.
      mem_valid = 1'b1; id_ri = 1'b1;
      for (int i = 0; i < 7; i++) begin
         sample();
         check_eq("ri_code",  32'(exccode_o), (i % 3 == 0) ? 32'h0a : 32'(EXC_NONE));
         check_eq("ri_flush", 32'(flush_o), 32'd1);
         check_eq("ri_busy",  32'(busy_o), (i % 3 == 0) ? 32'd0 : 32'd1);
         check_eq("ri_cnt",   32'(exc_cnt_o), 32'(5 + (i + 2) / 3));
         next_cycle();
      end
      clear_inputs();
      flush_phase("ri", 16'd8);

      // Reset in the first FLUSH cycle.
      mem_valid = 1'b1; ex_ov = 1'b1;
      sample();
      check_eq("rf_code", 32'(exccode_o), 32'h0c);
      next_cycle();
      clear_inputs();
      cpu_rst = 1'b1;
      sample();
      check_eq("rf_rst_flush", 32'(flush_o), 32'd0);
      check_eq("rf_rst_busy",  32'(busy_o), 32'd0);
      next_cycle();
      cpu_rst = 1'b0;
      sample();
      check_eq("rf_flush", 32'(flush_o), 32'd0);
      check_eq("rf_busy",  32'(busy_o), 32'd0);
      check_eq("rf_cnt",   32'(exc_cnt_o), 32'd0);
      check_eq("rf_state", 32'(dbg_state), 32'(ST_IDLE));
      next_cycle();

      // Normal operation resumes after reset.
      mem_valid = 1'b1; id_bp = 1'b1; mem_pc = 32'h00000040;
      sample();
      check_eq("bp_code", 32'(exccode_o), 32'h09);
      check_eq("bp_pc",   pc_o, 32'h00000040);
      next_cycle();
      clear_inputs();
      flush_phase("bp", 16'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
